sum_sq: RTL
===========

# sum_sq

Sequential sum-of-squares unit computing a·a + b·b with shift-add multiplication. It sits directly upstream of the 8-bit integer square-root stage and produces a saturated 8-bit operand for it, so the pair forms a vector-magnitude path. It uses the same start/busy handshake as the square-root stage. A one-cycle completion pulse can drive the square-root stage's start input directly.

## Interface
- No parameters; all widths fixed.
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- a_bi  input  8  operand a, unsigned.
- b_bi  input  8  operand b, unsigned.
- start_i  input  1  request; sampled only in IDLE.
- busy_o  output  1  high while a computation is in progress.
- done_o  output  1  one-cycle completion pulse.
- sum_bo  output  17  full result a·a + b·b.
- y_bo  output  8  result saturated to 255; feeds the square-root stage's x input.
- ovf_o  output  1  high when the full result exceeds 255.

## Operation
- Reset (rst_i high at an edge) has priority over everything else:
  - state ← IDLE.
  - busy_o, done_o, ovf_o ← 0; sum_bo, y_bo ← 0.
  - Internal accumulator and counter ← 0.
- States:
  - IDLE: busy_o = 0. If start_i is high, latch a_bi/b_bi into internal registers, clear the 17-bit accumulator, set bit counter = 0, go to MUL_A.
  - MUL_A: 8 cycles, one multiplier bit per cycle, LSB first. If a[cnt] = 1, acc ← acc + (a << cnt). cnt increments each cycle; on cnt = 7 go to MUL_B with cnt ← 0.
  - MUL_B: 8 cycles, same rule applied to operand b, adding into the same accumulator. On cnt = 7 go to FIN.
  - FIN: write the outputs, pulse done_o, go to IDLE.
- FIN output rules:
  - sum_bo ← acc.
  - ovf_o ← (acc > 255).
  - y_bo ← ovf ? 8'hFF : acc[7:0].
- Width rules:
  - Accumulator is 17 bits; maximum value is 2·255² = 130050, so it never wraps.
  - Shifted multiplicands are zero-extended to 17 bits.
- Output holding:
  - busy_o = (state ≠ IDLE).
  - done_o is registered: high only in the cycle after the FIN edge.
  - sum_bo, y_bo and ovf_o hold their values until the next FIN or reset.
- Boundary conditions:
  - start_i while busy: ignored, no queuing.
  - a_bi/b_bi changes after the start edge: no effect on the running computation.
  - start_i high during the done_o cycle: accepted, since the block is in IDLE. This gives back-to-back operation.
  - start_i held high continuously: a new computation starts every 18 cycles.
  - Reset mid-operation: aborts the computation; no done_o pulse; outputs zeroed.
  - Operand 0: every add is skipped; result is 0.

## Timing
- Latency, with start_i sampled at edge E0:
  - busy_o is high after E0 through E17.
  - MUL_A occupies E1..E8, MUL_B occupies E9..E16, FIN is at E17.
  - At E17: sum_bo, y_bo and ovf_o become valid, done_o goes high for one cycle, busy_o goes low.
- Total: 17 cycles start-to-result. Minimum issue interval is 18 cycles.
- Results are valid and stable from E17 onward. The square-root stage may sample y_bo whenever done_o is high.
- No combinational path from any input to any output.

## Test plan
- Reset then idle: all outputs 0, busy_o = 0. Then a = 3, b = 4, start pulse → busy_o high for 17 cycles, then done_o pulses once, sum_bo = 25, y_bo = 25, ovf_o = 0. Chained to the square-root stage, the root is 5.
- a = 15, b = 8 → sum_bo = 289, y_bo = 255, ovf_o = 1. Next run a = 0, b = 0 → sum_bo = 0, y_bo = 0, ovf_o = 0.
- a = 255, b = 255 → sum_bo = 130050, y_bo = 255, ovf_o = 1. Checks the 17-bit width with no wrap.
- Start with a = 5, b = 5:
  - Change a_bi/b_bi and pulse start_i at cycles 3 and 10 → ignored.
  - Single done_o at E17 with sum_bo = 50.
  - start_i high in the done_o cycle with a = 1, b = 2 → busy_o reasserts immediately; second result 5 at 18 cycles after the first.
- rst_i asserted at cycle 9 of a = 7, b = 9 run → next cycle all outputs 0, busy_o = 0, no done_o. A new start with a = 7, b = 9 then yields 130.
- Randomized sweep over all 65536 (a, b) pairs against a reference model. Checks sum_bo, y_bo and ovf_o, and that the latency is exactly 17 cycles every time.

Source files
------------

// File: rtl/sum_sq.sv
// rtl/sum_sq.sv - sequential shift-add sum of squares with saturated 8-bit output
module sum_sq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  a_bi,
  input  logic [7:0]  b_bi,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [16:0] sum_bo,
  output logic [7:0]  y_bo,
  output logic        ovf_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_A = 2'd1,
    MUL_B = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [16:0] acc;
  logic [2:0]  cnt;
  logic [7:0]  mcand;
  logic        mbit;
  logic [16:0] addend;

  // Select the operand being squared this phase and form its shifted partial product
  always_comb begin
    mcand  = (state == MUL_B) ? b_q : a_q;
    mbit   = mcand[cnt];
    addend = {9'd0, mcand} << cnt;
  end

  // Next-state logic: 8 bit-steps per operand, then one cycle to publish results
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = MUL_A;
      MUL_A:   if (cnt == 3'd7) state_nxt = MUL_B;
      MUL_B:   if (cnt == 3'd7) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: operand capture, shift-add accumulation and registered result outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
      done_o <= 1'b0;
      sum_bo <= '0;
      y_bo   <= '0;
      ovf_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            a_q <= a_bi;
            b_q <= b_bi;
            acc <= '0;
            cnt <= '0;
          end
        end
        MUL_A, MUL_B: begin
          // cnt wraps 7 -> 0 on its own, which restarts the count for MUL_B
          if (mbit) acc <= acc + addend;
          cnt <= cnt + 3'd1;
        end
        FIN: begin
          sum_bo <= acc;
          ovf_o  <= (acc > 17'd255);
          y_bo   <= (acc > 17'd255) ? 8'hFF : acc[7:0];
          done_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (state != IDLE);

endmodule
